// File: rtl/vector_pkg.sv
// Shared vector-unit types: ALU op encodings and sequencer states.
package vector_pkg;

  typedef enum logic [1:0] {
    eAdd  = 2'd0,
    eSub  = 2'd1,
    eMult = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eRun   = 2'd1,
    eDrain = 2'd2,
    eDone  = 2'd3
  } state_e;

  // Encoding 3 has no ALU meaning; a command carrying it is reported as an error.
  localparam int op_illegal_c = 3;

endpackage

// File: rtl/vector_alu_sequencer.sv
// Element-by-element sequencer: reads operand pairs from an external register
// file, streams them through an external ALU and writes results back, one
// element per cycle, then reports accumulated ALU flags until acknowledged.
module vector_alu_sequencer
  import vector_pkg::*;
#(
  parameter int vdw_p    = 32,
  parameter int op_len_p = 2,
  parameter int vlen_p   = 8,
  localparam int lw      = $clog2(vlen_p + 1),
  localparam int iw      = $clog2(vlen_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                cmd_v_i,
  output logic                cmd_ready_o,
  input  logic [op_len_p-1:0] cmd_op_i,
  input  logic [lw-1:0]       cmd_len_i,
  output logic                rd_v_o,
  output logic [iw-1:0]       rd_idx_o,
  input  logic [vdw_p-1:0]    rd_a_i,
  input  logic [vdw_p-1:0]    rd_b_i,
  output logic [vdw_p-1:0]    alu_a_o,
  output logic [vdw_p-1:0]    alu_b_o,
  output logic [op_len_p-1:0] alu_op_o,
  input  logic [vdw_p-1:0]    alu_result_i,
  input  logic                alu_ovf_i,
  input  logic                alu_zero_i,
  input  logic                alu_neg_i,
  output logic                wr_v_o,
  output logic [iw-1:0]       wr_idx_o,
  output logic [vdw_p-1:0]    wr_data_o,
  output logic                done_v_o,
  input  logic                done_yumi_i,
  output logic                done_ovf_o,
  output logic                done_zero_o,
  output logic                done_neg_o,
  output logic                done_err_o
);

  state_e              state_q;
  logic [lw-1:0]       count_q;
  logic [lw-1:0]       len_q;
  logic [op_len_p-1:0] op_q;
  logic                dly_v_q;
  logic [iw-1:0]       dly_idx_q;
  logic                ovf_q, zero_q, neg_q, err_q;

  logic                accept;
  logic                cmd_illegal;
  logic [lw-1:0]       len_sat;
  logic                last_issue;

  assign cmd_ready_o = (state_q == eIdle);
  assign accept      = cmd_v_i & cmd_ready_o;
  assign cmd_illegal = (cmd_op_i == op_len_p'(op_illegal_c));
  assign len_sat     = (cmd_len_i > lw'(vlen_p)) ? lw'(vlen_p) : cmd_len_i;
  assign last_issue  = (count_q == len_q - lw'(1));

  // Control FSM: latch the command, issue one read per cycle, drain the last
  // write, then hold completion until the consumer takes it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
      count_q <= '0;
      len_q   <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        eIdle: begin
          if (accept) begin
            op_q    <= cmd_op_i;
            len_q   <= len_sat;
            count_q <= '0;
            state_q <= (len_sat == '0 || cmd_illegal) ? eDone : eRun;
          end
        end
        eRun: begin
          count_q <= count_q + lw'(1);
          if (last_issue) state_q <= eDrain;
        end
        eDrain: state_q <= eDone;
        eDone: begin
          if (done_yumi_i) state_q <= eIdle;
        end
        default: state_q <= eIdle;
      endcase
    end
  end

  // Delay the read strobe and index by the register-file latency so the write
  // lines up with the operands arriving at the ALU.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dly_v_q   <= 1'b0;
      dly_idx_q <= '0;
    end else begin
      dly_v_q   <= (state_q == eRun);
      dly_idx_q <= (state_q == eRun) ? count_q[iw-1:0] : '0;
    end
  end

  // Summary flags: reset on acceptance (zero starts true so an empty vector
  // reports zero), then folded in with every write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      err_q  <= cmd_illegal;
    end else if (dly_v_q) begin
      ovf_q  <= ovf_q | alu_ovf_i;
      zero_q <= zero_q & alu_zero_i;
      neg_q  <= neg_q | alu_neg_i;
    end
  end

  assign rd_v_o      = (state_q == eRun);
  assign rd_idx_o    = rd_v_o ? count_q[iw-1:0] : '0;

  assign alu_a_o     = cmd_ready_o ? '0 : rd_a_i;
  assign alu_b_o     = cmd_ready_o ? '0 : rd_b_i;
  assign alu_op_o    = cmd_ready_o ? '0 : op_q;

  assign wr_v_o      = dly_v_q;
  assign wr_idx_o    = dly_v_q ? dly_idx_q : '0;
  assign wr_data_o   = dly_v_q ? alu_result_i : '0;

  assign done_v_o    = (state_q == eDone);
  assign done_ovf_o  = ovf_q;
  assign done_zero_o = zero_q;
  assign done_neg_o  = neg_q;
  assign done_err_o  = err_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer with a behavioural register file
// and ALU around it.
module tb_vector_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [3:0]  cmd_len_i;
  logic        rd_v_o;
  logic [2:0]  rd_idx_o;
  logic [31:0] rd_a_i, rd_b_i;
  logic [31:0] alu_a_o, alu_b_o;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_result_i;
  logic        alu_ovf_i, alu_zero_i, alu_neg_i;
  logic        wr_v_o;
  logic [2:0]  wr_idx_o;
  logic [31:0] wr_data_o;
  logic        done_v_o;
  logic        done_yumi_i;
  logic        done_ovf_o, done_zero_o, done_neg_o, done_err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];

  int          n_wr, n_rd, done_cyc;
  logic [2:0]  wr_idx_log  [16];
  logic [31:0] wr_data_log [16];
  int          wr_cyc_log  [16];

  vector_alu_sequencer #(.vdw_p(32), .op_len_p(2), .vlen_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i),
    .rd_v_o(rd_v_o), .rd_idx_o(rd_idx_o), .rd_a_i(rd_a_i), .rd_b_i(rd_b_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_ovf_i(alu_ovf_i),
    .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i),
    .wr_v_o(wr_v_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
    .done_v_o(done_v_o), .done_yumi_i(done_yumi_i),
    .done_ovf_o(done_ovf_o), .done_zero_o(done_zero_o),
    .done_neg_o(done_neg_o), .done_err_o(done_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file: operands appear one cycle after the read strobe.
  always @(posedge clk_i) begin
    if (rd_v_o) begin
      rd_a_i <= mem_a[rd_idx_o];
      rd_b_i <= mem_b[rd_idx_o];
    end
  end

  // Combinational ALU: signed overflow for add/sub, high-half nonzero for mult.
  always_comb begin
    logic [63:0] prod;
    prod         = 64'd0;
    alu_result_i = 32'd0;
    alu_ovf_i    = 1'b0;
    case (alu_op_o)
      2'd0: begin
        alu_result_i = alu_a_o + alu_b_o;
        alu_ovf_i = (alu_a_o[31] == alu_b_o[31]) && (alu_result_i[31] != alu_a_o[31]);
      end
      2'd1: begin
        alu_result_i = alu_a_o - alu_b_o;
        alu_ovf_i = (alu_a_o[31] != alu_b_o[31]) && (alu_result_i[31] != alu_a_o[31]);
      end
      2'd2: begin
        prod = {32'd0, alu_a_o} * {32'd0, alu_b_o};
        alu_result_i = prod[31:0];
        alu_ovf_i = |prod[63:32];
      end
      default: alu_result_i = 32'd0;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
    alu_neg_i  = alu_result_i[31];
  end

  // Present a command in cycle 0; returns at the start of cycle 1.
  task automatic issue_cmd(input logic [1:0] op, input logic [3:0] len);
    @(negedge clk_i);
    cmd_v_i   = 1'b1;
    cmd_op_i  = op;
    cmd_len_i = len;
    @(posedge clk_i);
    #1;
    cmd_v_i   = 1'b0;
    cmd_op_i  = 2'd0;
    cmd_len_i = 4'd0;
  endtask

  // Log reads/writes per cycle until done_v_o rises or the budget runs out.
  task automatic collect(input int budget);
    n_wr = 0; n_rd = 0; done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (rd_v_o) n_rd++;
      if (wr_v_o && n_wr < 16) begin
        wr_idx_log[n_wr]  = wr_idx_o;
        wr_data_log[n_wr] = wr_data_o;
        wr_cyc_log[n_wr]  = c;
        n_wr++;
      end
      if (done_v_o) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  // Acknowledge completion from within the eDone cycle.
  task automatic release_done();
    done_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    done_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({rd_v_o, wr_v_o, done_v_o, done_ovf_o, done_zero_o, done_neg_o, done_err_o} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=0000000",
               {rd_v_o, wr_v_o, done_v_o, done_ovf_o, done_zero_o, done_neg_o, done_err_o});
    end
    reset_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got=%b want=1", cmd_ready_o);
    end
  endtask

  task automatic test_add();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd11; exp_d[1] = 32'd12; exp_d[2] = 32'd13; exp_d[3] = 32'd14;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = 32'd10;
    end
    issue_cmd(2'd0, 4'd4);
    collect(20);
    total++;
    if (n_wr !== 4 || n_rd !== 4) begin
      bad++;
      $display("[TB] FAIL add_count got wr=%0d rd=%0d want 4/4", n_wr, n_rd);
    end
    for (int i = 0; i < 4 && i < n_wr; i++) begin
      total++;
      if (wr_idx_log[i] !== 3'(i) || wr_data_log[i] !== exp_d[i] || wr_cyc_log[i] !== i + 2) begin
        bad++;
        $display("[TB] FAIL add_wr%0d got idx=%0d data=%0d cyc=%0d want idx=%0d data=%0d cyc=%0d",
                 i, wr_idx_log[i], wr_data_log[i], wr_cyc_log[i], i, exp_d[i], i + 2);
      end
    end
    total++;
    if (done_cyc !== 6) begin
      bad++;
      $display("[TB] FAIL add_done_cycle got=%0d want=6", done_cyc);
    end
    total++;
    if ({done_ovf_o, done_zero_o, done_neg_o, done_err_o} !== 4'b0000 || cmd_ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_flags got ovf/zero/neg/err=%b ready=%b want 0000 ready=0",
               {done_ovf_o, done_zero_o, done_neg_o, done_err_o}, cmd_ready_o);
    end
    release_done();
    @(negedge clk_i);
    total++;
    if (cmd_ready_o !== 1'b1 || done_v_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_return_idle got ready=%b done=%b want 1/0", cmd_ready_o, done_v_o);
    end
  endtask

  task automatic test_sub();
    mem_a[0] = 32'd5; mem_b[0] = 32'd5;
    mem_a[1] = 32'd0; mem_b[1] = 32'd1;
    issue_cmd(2'd1, 4'd2);
    collect(20);
    total++;
    if (n_wr !== 2 || wr_data_log[0] !== 32'd0 || wr_data_log[1] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("[TB] FAIL sub_writes got n=%0d d0=%h d1=%h want 2 00000000 ffffffff",
               n_wr, wr_data_log[0], wr_data_log[1]);
    end
    total++;
    if (done_cyc !== 4 || done_zero_o !== 1'b0 || done_neg_o !== 1'b1 || done_ovf_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_flags got cyc=%0d zero=%b neg=%b ovf=%b want 4 0 1 0",
               done_cyc, done_zero_o, done_neg_o, done_ovf_o);
    end
    total++;
    if (alu_op_o !== 2'd1) begin
      bad++;
      $display("[TB] FAIL sub_alu_op got=%0d want=1", alu_op_o);
    end
    release_done();
  endtask

  task automatic test_illegal_and_empty();
    issue_cmd(2'd3, 4'd3);
    collect(10);
    total++;
    if (n_rd !== 0 || n_wr !== 0 || done_cyc !== 1 || done_err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL illegal_op got rd=%0d wr=%0d cyc=%0d err=%b want 0 0 1 1",
               n_rd, n_wr, done_cyc, done_err_o);
    end
    release_done();
    issue_cmd(2'd0, 4'd0);
    collect(10);
    total++;
    if (n_wr !== 0 || done_cyc !== 1 || done_zero_o !== 1'b1 || done_err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len_zero got wr=%0d cyc=%0d zero=%b err=%b want 0 1 1 0",
               n_wr, done_cyc, done_zero_o, done_err_o);
    end
    release_done();
  endtask

  task automatic test_mult_hold();
    int unstable;
    for (int i = 0; i < 7; i++) begin
      mem_a[i] = 32'd1;
      mem_b[i] = 32'd1;
    end
    mem_a[7] = 32'h0001_0000;
    mem_b[7] = 32'h0001_0000;
    issue_cmd(2'd2, 4'd8);
    collect(30);
    total++;
    if (n_wr !== 8 || done_cyc !== 10 || wr_idx_log[7] !== 3'd7 || wr_data_log[7] !== 32'd0) begin
      bad++;
      $display("[TB] FAIL mult_run got n=%0d cyc=%0d idx7=%0d d7=%h want 8 10 7 0",
               n_wr, done_cyc, wr_idx_log[7], wr_data_log[7]);
    end
    total++;
    if (done_ovf_o !== 1'b1 || done_zero_o !== 1'b0 || done_neg_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mult_flags got ovf=%b zero=%b neg=%b want 1 0 0",
               done_ovf_o, done_zero_o, done_neg_o);
    end
    unstable = 0;
    cmd_v_i   = 1'b1;
    cmd_op_i  = 2'd0;
    cmd_len_i = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (done_v_o !== 1'b1 || done_ovf_o !== 1'b1 || done_zero_o !== 1'b0 ||
          cmd_ready_o !== 1'b0 || wr_v_o !== 1'b0 || rd_v_o !== 1'b0)
        unstable++;
    end
    cmd_v_i   = 1'b0;
    cmd_len_i = 4'd0;
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("[TB] FAIL mult_hold got %0d unstable cycles want 0", unstable);
    end
    release_done();
  endtask

  task automatic test_reset_mid();
    int late_wr, late_done, not_ready;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 32'(i);
      mem_b[i] = 32'd1;
    end
    issue_cmd(2'd0, 4'd8);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if (rd_v_o !== 1'b1 || rd_idx_o !== 3'd2 || wr_v_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_pre got rd=%b idx=%0d wr=%b want 1 2 1", rd_v_o, rd_idx_o, wr_v_o);
    end
    #1 reset_n_i = 1'b0;
    #1;
    total++;
    if ({rd_v_o, wr_v_o, done_v_o, rd_idx_o, wr_idx_o, done_ovf_o, done_zero_o, done_neg_o} !== 11'b0 ||
        wr_data_o !== 32'd0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_async got rd=%b wr=%b done=%b ridx=%0d widx=%0d wdata=%h zero=%b ready=%b want all 0 ready=1",
               rd_v_o, wr_v_o, done_v_o, rd_idx_o, wr_idx_o, wr_data_o, done_zero_o, cmd_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    late_wr = 0; late_done = 0; not_ready = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (wr_v_o) late_wr++;
      if (done_v_o) late_done++;
      if (cmd_ready_o !== 1'b1) not_ready++;
    end
    total++;
    if (late_wr !== 0 || late_done !== 0 || not_ready !== 0) begin
      bad++;
      $display("[TB] FAIL midrst_after got wr=%0d done=%0d notready=%0d want 0 0 0",
               late_wr, late_done, not_ready);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 32'd2;
      mem_b[i] = 32'd3;
    end
    issue_cmd(2'd0, 4'd15);
    collect(30);
    total++;
    if (n_wr !== 8 || n_rd !== 8 || done_cyc !== 10 || wr_idx_log[7] !== 3'd7 || wr_data_log[7] !== 32'd5) begin
      bad++;
      $display("[TB] FAIL saturate got wr=%0d rd=%0d cyc=%0d idx7=%0d d7=%0d want 8 8 10 7 5",
               n_wr, n_rd, done_cyc, wr_idx_log[7], wr_data_log[7]);
    end
    release_done();
  endtask

  initial begin
    reset_n_i   = 1'b0;
    cmd_v_i     = 1'b0;
    cmd_op_i    = 2'd0;
    cmd_len_i   = 4'd0;
    done_yumi_i = 1'b0;
    rd_a_i      = 32'd0;
    rd_b_i      = 32'd0;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    test_reset();
    test_add();
    test_sub();
    test_illegal_and_empty();
    test_mult_hold();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 SHALL have parameters: vdw_p, default 32, element data width; op_len_p, default 2, ALU op width; vlen_p, default 8, maximum elements per vector.
REQ-002 SHALL define lw = clog2(vlen_p+1), the length field width, and iw = clog2(vlen_p), the index width.
REQ-003 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  op_len_p  op: 0 add, 1 sub, 2 mult, 3 illegal
- cmd_len_i  in  lw  element count, 0..vlen_p
- rd_v_o  out  1  register-file read strobe
- rd_idx_o  out  iw  element index read
- rd_a_i  in  vdw_p  operand A, valid one cycle after rd_v_o
- rd_b_i  in  vdw_p  operand B, valid one cycle after rd_v_o
- alu_a_o  out  vdw_p  ALU operand A
- alu_b_o  out  vdw_p  ALU operand B
- alu_op_o  out  op_len_p  ALU op
- alu_result_i  in  vdw_p  ALU result, combinational
- alu_ovf_i, alu_zero_i, alu_neg_i  in  1 each  ALU flags
- wr_v_o  out  1  write strobe
- wr_idx_o  out  iw  write index
- wr_data_o  out  vdw_p  write data
- done_v_o  out  1  completion valid
- done_yumi_i  in  1  completion consumed
- done_ovf_o, done_zero_o, done_neg_o, done_err_o  out  1 each  summary flags

Function
REQ-004 SHALL implement the states eIdle, eRun, eDrain and eDone.
REQ-005 SHALL assert cmd_ready_o only in eIdle; a command is accepted when cmd_v_i and cmd_ready_o are both high, and the sequencer then latches op and len.
REQ-006 SHALL handle an accepted command as follows:
- len ≥ 1 and op ≠ 3: go to eRun with the counter at 0.
- len = 0, or op = 3: go directly to eDone with no reads and no writes.
- op = 3: done_err_o = 1.
REQ-007 In eRun, each cycle SHALL assert rd_v_o with rd_idx_o = counter and increment the counter; the cycle in which counter = len-1 is issued SHALL transition to eDrain.
REQ-008 SHALL register rd_v_o and rd_idx_o one cycle; when the delayed valid is high it SHALL assert wr_v_o with wr_idx_o = delayed index and wr_data_o = alu_result_i.
REQ-009 SHALL drive alu_a_o = rd_a_i, alu_b_o = rd_b_i and alu_op_o = the latched op at all times outside eIdle.
REQ-010 SHALL sustain a throughput of one element per cycle.
REQ-011 For a command accepted in cycle 0 with length L, SHALL produce reads in cycles 1..L, writes in cycles 2..L+1, eDrain in cycle L+1 and done_v_o from cycle L+2.
REQ-012 SHALL treat eDrain as exactly one cycle that issues the final write, followed by eDone.
REQ-013 SHALL hold done_v_o and the summary flags stable in eDone until done_yumi_i is high, then return to eIdle on the next cycle; a new command cannot be accepted in that same cycle.
REQ-014 SHALL accumulate summary flags on every write:
- done_ovf_o: OR of alu_ovf_i.
- done_neg_o: OR of alu_neg_i.
- done_zero_o: AND of alu_zero_i.
- All are cleared on command acceptance; done_zero_o is preset to 1, so a len = 0 command reports zero = 1.
REQ-015 SHALL treat cmd_len_i > vlen_p as vlen_p, saturating.
REQ-016 SHALL ignore done_yumi_i outside eDone and cmd_v_i outside eIdle.
REQ-017 Whenever wr_v_o or rd_v_o is low, SHALL drive the corresponding index and data outputs to 0.

Reset
REQ-018 Asserting reset_n_i low SHALL immediately force, asynchronously:
- state = eIdle;
- counter, the delayed valid and the delayed index = 0;
- all summary flags = 0;
- rd_v_o = wr_v_o = done_v_o = 0 and cmd_ready_o = 1 after deassertion.
REQ-019 Reset asserted mid-operation SHALL abort the operation with no further writes, and no done SHALL be reported for the aborted command.

Structure
REQ-020 SHALL take the eOp enum (eAdd = 0, eSub = 1, eMult = 2) and the state enum from a shared package, vector_pkg, which the ALU also uses.
REQ-021 SHALL be a single module with no sub-modules; the ALU and the register file are external.

Verification
REQ-022 The bench SHALL cover an add with len = 4, A = {1,2,3,4}, B = {10,10,10,10}, accepted in cycle 0: writes {11,12,13,14} at idx 0..3 in cycles 2..5, done_v_o in cycle 6, ovf = 0, zero = 0, neg = 0.
REQ-023 The bench SHALL cover a sub with len = 2, A = {5,0}, B = {5,1}: writes {0,0xFFFFFFFF}, done_zero_o = 0, done_neg_o = 1.
REQ-024 The bench SHALL cover op = 3 with len = 3: no rd_v_o or wr_v_o, done_v_o in cycle 1, done_err_o = 1; and len = 0 with op add: done_v_o in cycle 1, done_zero_o = 1.
REQ-025 The bench SHALL cover a mult with len = 8 at full vlen, 0x10000×0x10000 on element 7 only: done_ovf_o = 1; done_yumi_i held low for 5 cycles keeps done_v_o and the flags stable, and cmd_ready_o = 0 throughout.
REQ-026 The bench SHALL cover reset_n_i asserted low in cycle 3 of a len = 8 add: outputs clear immediately, no writes follow, and cmd_ready_o = 1 after release.
REQ-027 The bench SHALL cover cmd_len_i = 15 with vlen_p = 8: exactly 8 writes.
